// File: rtl/stopwatch_pkg.sv
// Shared constants, state encodings and helpers for the stopwatch serial reporter.
package stopwatch_pkg;

    localparam logic [7:0] ASCII_COLON      = 8'h3A;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_BAD_DIGIT  = 8'h3F;

    // Index of the last byte of "MM:SS\r\n".
    localparam int LINE_LAST_IDX = 6;

    // Integer truncation; callers must keep the result at 2 or more.
    function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_SEND,
        SEQ_WAIT_BYTE
    } seq_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START_BIT,
        TX_DATA,
        TX_STOP_BIT
    } tx_state_e;

    // Non-BCD values are shown as '?' so a corrupted digit is visible on the host.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return ASCII_DIGIT_BASE + {4'h0, digit};
        end
        return ASCII_BAD_DIGIT;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, one stop bit.
//
// state        | meaning
// -------------+-------------------------------------------------
// TX_IDLE      | line high, waiting for send
// TX_START_BIT | driving the low start bit
// TX_DATA      | shifting out data bits, bit_q counts 0..7
// TX_STOP_BIT  | driving the high stop bit, done on its last cycle
module uart_tx_byte
    import stopwatch_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       ready
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              bit_end;

    assign bit_end = (baud_q == BAUD_LAST);
    assign tx      = tx_q;
    assign ready   = (state_q == TX_IDLE);

    // State, counters and the registered line output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; the baud counter restarts at every byte so there is no drift.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done    = 1'b0;

        if (state_q != TX_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (send) begin
                    shreg_d = data;
                    tx_d    = 1'b0;
                    state_d = TX_START_BIT;
                end
            end
            TX_START_BIT: begin
                if (bit_end) begin
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP_BIT;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end
            end
            TX_STOP_BIT: begin
                if (bit_end) begin
                    done    = 1'b1;
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/time_uart_reporter.sv
// Sends the latched MM:SS digits as one "MM:SS\r\n" line over UART per start request.
//
// state         | meaning
// --------------+--------------------------------------------------
// SEQ_IDLE      | waiting for start, snapshot taken on acceptance
// SEQ_LOAD      | registering the byte at the current index
// SEQ_SEND      | one-cycle send pulse to the byte transmitter
// SEQ_WAIT_BYTE | waiting for done, then next index or back to idle
module time_uart_reporter
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] minutes_10,
    input  logic [3:0] minutes_1,
    input  logic [3:0] seconds_10,
    input  logic [3:0] seconds_1,
    output logic       usb_tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

    seq_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] snap_q, snap_d;
    logic [7:0]  byte_q, byte_d;
    logic        busy_q;
    logic [7:0]  line_byte;
    logic        send;
    logic        tx_done;
    logic        tx_ready;

    assign busy = busy_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .send (send),
        .data (byte_q),
        .tx   (usb_tx),
        .done (tx_done),
        .ready(tx_ready)
    );

    // Character at the current line index, taken from the snapshot only.
    always_comb begin
        line_byte = ASCII_LF;
        case (idx_q)
            3'd0:    line_byte = bcd_to_ascii(snap_q[15:12]);
            3'd1:    line_byte = bcd_to_ascii(snap_q[11:8]);
            3'd2:    line_byte = ASCII_COLON;
            3'd3:    line_byte = bcd_to_ascii(snap_q[7:4]);
            3'd4:    line_byte = bcd_to_ascii(snap_q[3:0]);
            3'd5:    line_byte = ASCII_CR;
            default: line_byte = ASCII_LF;
        endcase
    end

    // Sequencer registers; busy lags the state by one cycle so it stays up
    // through the cycle after the final done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            byte_q  <= byte_d;
            busy_q  <= (state_q != SEQ_IDLE);
        end
    end

    // Sequencer next state; start is only honoured once busy has dropped,
    // so a request on the cycle busy falls is discarded.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        byte_d  = byte_q;
        send    = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (start && !busy_q) begin
                    snap_d  = {minutes_10, minutes_1, seconds_10, seconds_1};
                    state_d = SEQ_LOAD;
                end
            end
            SEQ_LOAD: begin
                byte_d  = line_byte;
                state_d = SEQ_SEND;
            end
            SEQ_SEND: begin
                if (tx_ready) begin
                    send    = 1'b1;
                    state_d = SEQ_WAIT_BYTE;
                end
            end
            SEQ_WAIT_BYTE: begin
                if (tx_done) begin
                    if (idx_q == 3'(LINE_LAST_IDX)) begin
                        idx_d   = '0;
                        state_d = SEQ_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEQ_LOAD;
                    end
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_time_uart_reporter.sv
// Directed bench: decodes the UART line cycle-exactly and checks content and timing.
module tb_time_uart_reporter;

    localparam logic [55:0] LINE_1234 = 56'h31_32_3A_33_34_0D_0A;
    localparam logic [55:0] LINE_0742 = 56'h30_37_3A_34_32_0D_0A;
    localparam logic [55:0] LINE_C234 = 56'h3F_32_3A_33_34_0D_0A;
    localparam logic [55:0] LINE_5959 = 56'h35_39_3A_35_39_0D_0A;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start2;
    logic [3:0] m10, m1, s10, s1;
    logic       tx1, busy1, tx2, busy2;
    logic       sel2;
    logic       rx_line, busy_s;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         t_acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rx_line = sel2 ? tx2 : tx1;
    assign busy_s  = sel2 ? busy2 : busy1;

    time_uart_reporter #(
        .CLK_FREQ_HZ(16),
        .BAUD_RATE  (1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .minutes_10(m10),
        .minutes_1 (m1),
        .seconds_10(s10),
        .seconds_1 (s1),
        .usb_tx    (tx1),
        .busy      (busy1)
    );

    time_uart_reporter u_dut_dflt (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start2),
        .minutes_10(m10),
        .minutes_1 (m1),
        .seconds_10(s10),
        .seconds_1 (s1),
        .usb_tx    (tx2),
        .busy      (busy2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        m10 = a; m1 = b; s10 = c; s1 = d;
    endtask

    // Start is sampled at edge t_acc; returns at the negedge following that edge.
    task automatic pulse_start();
        @(negedge clk);
        if (sel2) start2 = 1'b1; else start = 1'b1;
        t_acc = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Receives one frame; every bit is sampled on its first and last cycle.
    task automatic rx_byte(input int cpb, output logic [7:0] data, output logic ok, output int t0);
        int   guard;
        logic first, last;
        ok    = 1'b1;
        data  = '0;
        guard = 0;
        while (rx_line !== 1'b0 && guard < 4 * cpb + 8) begin
            @(negedge clk);
            guard++;
        end
        t0 = cyc;
        if (rx_line !== 1'b0) begin
            ok = 1'b0;
        end else begin
            for (int j = 0; j < 10; j++) begin
                first = rx_line;
                repeat (cpb - 1) @(negedge clk);
                last = rx_line;
                if (first !== last) ok = 1'b0;
                if (j == 0 && first !== 1'b0) ok = 1'b0;
                if (j == 9 && first !== 1'b1) ok = 1'b0;
                if (j >= 1 && j <= 8) data[j-1] = first;
                if (j < 9) @(negedge clk);
            end
        end
    endtask

    // Called at the negedge right after the accepting edge t_acc.
    task automatic run_line(input int cpb, input logic [55:0] exp, input string name, input bit hold);
        int         t0, guard;
        logic [7:0] b;
        logic       ok;
        check_val({name, ".busy_pre"}, {31'd0, busy_s}, 32'd0);
        @(negedge clk);
        check_val({name, ".busy_rise"}, {31'd0, busy_s}, 32'd1);
        for (int k = 0; k < 7; k++) begin
            rx_byte(cpb, b, ok, t0);
            check_val($sformatf("%s.byte%0d", name, k), {24'd0, b}, {24'd0, exp[55-8*k -: 8]});
            check_val($sformatf("%s.frame%0d", name, k), {31'd0, ok}, 32'd1);
            check_val($sformatf("%s.tstart%0d", name, k), t0 - t_acc, 2 + k * (10 * cpb + 2));
        end
        @(negedge clk);
        if (hold) start = 1'b1;
        guard = 0;
        while (busy_s === 1'b1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        check_val({name, ".busy_len"}, cyc - (t_acc + 1), 7 * (10 * cpb + 2));
    endtask

    initial begin
        int lows;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        sel2   = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (3) @(negedge clk);
        check_val("rst.tx", {31'd0, tx1}, 32'd1);
        check_val("rst.busy", {31'd0, busy1}, 32'd0);
        check_val("rst.tx_dflt", {31'd0, tx2}, 32'd1);
        check_val("rst.busy_dflt", {31'd0, busy2}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal line
        pulse_start();
        run_line(16, LINE_1234, "t1", 1'b0);

        // Snapshot holds while digits change right after start
        repeat (4) @(negedge clk);
        pulse_start();
        set_digits(4'd5, 4'd9, 4'd5, 4'd9);
        run_line(16, LINE_1234, "t2", 1'b0);

        // Start during byte 3 ignored; start on the busy-fall edge ignored,
        // held one more cycle it begins the next line with new digits
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (4) @(negedge clk);
        pulse_start();
        fork
            run_line(16, LINE_1234, "t3a", 1'b1);
            begin
                repeat (2 + 3 * 162 + 40) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                set_digits(4'd0, 4'd7, 4'd4, 4'd2);
            end
        join
        t_acc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        run_line(16, LINE_0742, "t3b", 1'b0);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (rx_line !== 1'b1 || busy_s !== 1'b0) lows++;
        end
        check_val("t3.quiet_after", lows, 0);

        // Invalid BCD in minutes tens
        set_digits(4'hC, 4'd2, 4'd3, 4'd4);
        pulse_start();
        run_line(16, LINE_C234, "t4", 1'b0);

        // Reset during data bit 0 of byte 2
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (4) @(negedge clk);
        pulse_start();
        repeat (2 + 2 * 162 + 16 + 5) @(negedge clk);
        check_val("t5.tx_low_pre", {31'd0, tx1}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("t5.tx_after_rst", {31'd0, tx1}, 32'd1);
        check_val("t5.busy_after_rst", {31'd0, busy1}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("t5.tx_idle", {31'd0, tx1}, 32'd1);
        pulse_start();
        run_line(16, LINE_1234, "t5", 1'b0);

        // Default parameters: 868 cycles per bit, 60774 busy cycles
        sel2 = 1'b1;
        set_digits(4'd5, 4'd9, 4'd5, 4'd9);
        repeat (2) @(negedge clk);
        pulse_start();
        run_line(868, LINE_5959, "t6", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
